x_m_stage: RTL and testbench

X_M_STAGE -- requirements
Module: x_m_stage

---
 rtl/x_m_stage.sv | 124 ++++++++++++
 tb/tb_x_m_stage.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/x_m_stage.sv
// Memory stage: issues one data-memory request per load/store and presents the result to writeback.
// Optional XM_ALIGN_CHECK_EN: misaligned memory ops skip the request and are flagged on err_out.
module x_m_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [15:0] alu_result_in,
  input  logic [15:0] reg2data_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        MemToReg_in,
  input  logic        RegWrite_in,
  input  logic        halt_in,
  input  logic [2:0]  writereg_in,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_done,
  output logic        stall_out,
  output logic        valid_out,
  output logic [15:0] alu_result_out,
  output logic [15:0] mem_rdata_out,
  output logic        MemToReg_out,
  output logic        RegWrite_out,
  output logic        halt_out,
  output logic [2:0]  writereg_out,
  output logic        halted_out,
  output logic        err_out
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state;
  logic        m_valid;
  logic [15:0] m_alu;
  logic [15:0] m_wdata;
  logic        m_mem_read;
  logic        m_mem_write;
  logic        m_mem_to_reg;
  logic        m_reg_write;
  logic        m_halt;
  logic [2:0]  m_writereg;
  logic        m_err;
  logic        halted;
  logic [15:0] rdata_q;
  logic        is_mem_in;
  logic        misaligned;

  assign is_mem_in = valid_in & (MemRead_in | MemWrite_in);

`ifdef XM_ALIGN_CHECK_EN
  assign misaligned = is_mem_in & alu_result_in[0];
`else
  assign misaligned = 1'b0;
`endif

  // A halting instruction being emitted freezes the stage instead of accepting the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      m_valid      <= 1'b0;
      m_alu        <= '0;
      m_wdata      <= '0;
      m_mem_read   <= 1'b0;
      m_mem_write  <= 1'b0;
      m_mem_to_reg <= 1'b0;
      m_reg_write  <= 1'b0;
      m_halt       <= 1'b0;
      m_writereg   <= '0;
      m_err        <= 1'b0;
      halted       <= 1'b0;
      rdata_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!halted) begin
            if (m_valid && m_halt) begin
              halted  <= 1'b1;
              m_valid <= 1'b0;
            end else begin
              m_valid      <= valid_in;
              m_alu        <= alu_result_in;
              m_wdata      <= reg2data_in;
              m_mem_read   <= MemRead_in;
              m_mem_write  <= MemWrite_in;
              m_mem_to_reg <= MemToReg_in;
              m_reg_write  <= RegWrite_in;
              m_halt       <= halt_in;
              m_writereg   <= writereg_in;
              m_err        <= misaligned;
              state        <= (is_mem_in && !misaligned) ? REQ : IDLE;
            end
          end
        end
        REQ: state <= WAIT;
        WAIT: begin
          if (mem_done) begin
            state <= IDLE;
            if (m_mem_read) rdata_q <= mem_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall_out      = (state != IDLE);
  assign mem_en         = (state == REQ);
  assign mem_wr         = (state == REQ) & m_mem_write;
  assign mem_addr       = m_alu;
  assign mem_wdata      = m_wdata;
  assign valid_out      = m_valid & (state == IDLE);
  assign alu_result_out = m_alu;
  assign mem_rdata_out  = rdata_q;
  assign MemToReg_out   = m_mem_to_reg;
  assign RegWrite_out   = valid_out & m_reg_write & ~m_err;
  assign halt_out       = valid_out & m_halt;
  assign writereg_out   = m_writereg;
  assign halted_out     = halted;
  assign err_out        = valid_out & m_err;

endmodule

// File: tb/tb_x_m_stage.sv
// Randomized self-checking bench for x_m_stage against a transaction-level model,
// preceded by directed sequences with hand-computed expectations.
module tb_x_m_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [15:0] alu_result_in;
  logic [15:0] reg2data_in;
  logic        MemRead_in;
  logic        MemWrite_in;
  logic        MemToReg_in;
  logic        RegWrite_in;
  logic        halt_in;
  logic [2:0]  writereg_in;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_done;
  logic        stall_out;
  logic        valid_out;
  logic [15:0] alu_result_out;
  logic [15:0] mem_rdata_out;
  logic        MemToReg_out;
  logic        RegWrite_out;
  logic        halt_out;
  logic [2:0]  writereg_out;
  logic        halted_out;
  logic        err_out;

  int checks = 0;
  int errors = 0;

  // Model: the instruction held in the stage, its age in cycles and whether memory answered.
  bit          mv, mrd, mwr, mmtr, mrw, mhalt, mmis, mdone, mhalted;
  logic [2:0]  mwreg;
  logic [15:0] malu, mwd, mrdata;
  int          mage;
  int          halted_cycles;

  x_m_stage dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .alu_result_in(alu_result_in),
    .reg2data_in(reg2data_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .MemToReg_in(MemToReg_in), .RegWrite_in(RegWrite_in), .halt_in(halt_in),
    .writereg_in(writereg_in), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .stall_out(stall_out), .valid_out(valid_out), .alu_result_out(alu_result_out),
    .mem_rdata_out(mem_rdata_out), .MemToReg_out(MemToReg_out),
    .RegWrite_out(RegWrite_out), .halt_out(halt_out), .writereg_out(writereg_out),
    .halted_out(halted_out), .err_out(err_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit busy();
    return mv && (mrd || mwr) && !mmis && !mdone;
  endfunction

  task automatic model_reset();
    mv = 0; mrd = 0; mwr = 0; mmtr = 0; mrw = 0; mhalt = 0; mmis = 0; mdone = 0;
    mhalted = 0; mwreg = '0; malu = '0; mwd = '0; mrdata = '0; mage = 0;
  endtask

  // Per-cycle compare of every output against the model.
  task automatic checkOutput();
    bit b, ev;
    b  = busy();
    ev = mv && !b;
    chk("stall_out", stall_out, b);
    chk("valid_out", valid_out, ev);
    chk("mem_en", mem_en, b && mage == 1);
    chk("mem_wr", mem_wr, b && mage == 1 && mwr);
    chk("RegWrite_out", RegWrite_out, ev && mrw && !mmis);
    chk("halt_out", halt_out, ev && mhalt);
    chk("err_out", err_out, ev && mmis);
    chk("halted_out", halted_out, mhalted);
    chk("mem_rdata_out", mem_rdata_out, mrdata);
    if (b) begin
      chk("mem_addr", mem_addr, malu);
      chk("mem_wdata", mem_wdata, mwd);
    end
    if (ev) begin
      chk("alu_result_out", alu_result_out, malu);
      chk("writereg_out", {13'd0, writereg_out}, {13'd0, mwreg});
      chk("MemToReg_out", MemToReg_out, mmtr);
    end
  endtask

  // What the coming rising edge does to the held instruction.
  task automatic model_advance();
    bit b, ev;
    b  = busy();
    ev = mv && !b;
    if (b) begin
      if (mage >= 2 && mem_done) begin
        mdone = 1;
        if (mrd) mrdata = mem_rdata;
      end
      mage++;
    end else if (!mhalted) begin
      if (ev && mhalt) begin
        mhalted = 1;
        mv = 0;
      end else begin
        mv = valid_in; mrd = MemRead_in; mwr = MemWrite_in; mmtr = MemToReg_in;
        mrw = RegWrite_in; mhalt = halt_in; mwreg = writereg_in;
        malu = alu_result_in; mwd = reg2data_in;
`ifdef XM_ALIGN_CHECK_EN
        mmis = valid_in && (MemRead_in || MemWrite_in) && alu_result_in[0];
`else
        mmis = 0;
`endif
        mage = 1; mdone = 0;
      end
    end
  endtask

  task automatic set_in(input bit v, rd, wr, mtr, rw, hlt, input logic [2:0] wreg,
                        input logic [15:0] alu, wd);
    valid_in = v; MemRead_in = rd; MemWrite_in = wr; MemToReg_in = mtr;
    RegWrite_in = rw; halt_in = hlt; writereg_in = wreg;
    alu_result_in = alu; reg2data_in = wd;
  endtask

  task automatic applyStimulus();
    set_in($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           1'($urandom), 1'($urandom), $urandom_range(0, 19) == 0,
           3'($urandom), 16'($urandom), 16'($urandom));
    mem_done  = 1'($urandom);
    mem_rdata = 16'($urandom);
  endtask

  task automatic half();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic finish_cycle();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse in the middle of a cycle.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst stall_out", stall_out, 1'b0);
    chk("rst valid_out", valid_out, 1'b0);
    chk("rst mem_en", mem_en, 1'b0);
    chk("rst halted_out", halted_out, 1'b0);
    chk("rst mem_rdata_out", mem_rdata_out, 16'h0000);
    chk("rst alu_result_out", alu_result_out, 16'h0000);
    chk("rst mem_addr", mem_addr, 16'h0000);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0);
    mem_done = 1'b0;
    mem_rdata = 16'h0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // ALU result passes straight through the next cycle.
    set_in(1, 0, 0, 0, 1, 0, 3'd1, 16'h1234, 16'h0);
    half(); finish_cycle();
    set_in(0, 0, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0);
    half();
    chk("add valid_out", valid_out, 1'b1);
    chk("add alu_result_out", alu_result_out, 16'h1234);
    chk("add stall_out", stall_out, 1'b0);
    finish_cycle();

    // Load answered two cycles after the request.
    set_in(1, 1, 0, 1, 1, 0, 3'd3, 16'h0040, 16'h0);
    half(); finish_cycle();
    set_in(0, 0, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0);
    half();
    chk("load c1 stall", stall_out, 1'b1);
    chk("load c1 mem_en", mem_en, 1'b1);
    finish_cycle();
    half();
    chk("load c2 stall", stall_out, 1'b1);
    chk("load c2 mem_en", mem_en, 1'b0);
    finish_cycle();
    mem_done = 1'b1; mem_rdata = 16'hBEEF;
    half();
    chk("load c3 stall", stall_out, 1'b1);
    finish_cycle();
    mem_done = 1'b0;
    half();
    chk("load valid_out", valid_out, 1'b1);
    chk("load mem_rdata_out", mem_rdata_out, 16'hBEEF);
    chk("load MemToReg_out", MemToReg_out, 1'b1);
    chk("load stall_out", stall_out, 1'b0);
    finish_cycle();

    // Store answered in the first wait cycle leaves read data alone.
    set_in(1, 0, 1, 0, 0, 0, 3'd0, 16'h0010, 16'h5A5A);
    half(); finish_cycle();
    set_in(0, 0, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0);
    half();
    chk("store mem_en", mem_en, 1'b1);
    chk("store mem_wr", mem_wr, 1'b1);
    chk("store mem_wdata", mem_wdata, 16'h5A5A);
    chk("store mem_addr", mem_addr, 16'h0010);
    finish_cycle();
    mem_done = 1'b1; mem_rdata = 16'h1111;
    half();
    chk("store wait mem_en", mem_en, 1'b0);
    finish_cycle();
    mem_done = 1'b0;
    half();
    chk("store valid_out", valid_out, 1'b1);
    chk("store RegWrite_out", RegWrite_out, 1'b0);
    chk("store mem_rdata_out", mem_rdata_out, 16'hBEEF);
    finish_cycle();

    // Reset while waiting on memory; the late response must be dropped.
    set_in(1, 1, 0, 1, 1, 0, 3'd2, 16'h0080, 16'h0);
    half(); finish_cycle();
    set_in(0, 0, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0);
    half(); finish_cycle();
    do_reset();
    mem_done = 1'b1; mem_rdata = 16'h1234;
    half(); finish_cycle();
    mem_done = 1'b0;
    half();
    chk("post-rst valid_out", valid_out, 1'b0);
    chk("post-rst mem_rdata_out", mem_rdata_out, 16'h0000);
    finish_cycle();

    // Halt followed by a load: the load never reaches memory.
    set_in(1, 0, 0, 0, 1, 1, 3'd4, 16'h0007, 16'h0);
    half(); finish_cycle();
    set_in(1, 1, 0, 1, 1, 0, 3'd5, 16'h0040, 16'h0);
    half();
    chk("halt halt_out", halt_out, 1'b1);
    chk("halt valid_out", valid_out, 1'b1);
    finish_cycle();
    half();
    chk("halted halted_out", halted_out, 1'b1);
    chk("halted halt_out", halt_out, 1'b0);
    chk("halted mem_en", mem_en, 1'b0);
    finish_cycle();
    half();
    chk("halted2 halted_out", halted_out, 1'b1);
    chk("halted2 mem_en", mem_en, 1'b0);
    chk("halted2 valid_out", valid_out, 1'b0);
    finish_cycle();
    do_reset();

`ifdef XM_ALIGN_CHECK_EN
    // Misaligned load is flagged and never issued.
    set_in(1, 1, 0, 1, 1, 0, 3'd6, 16'h0003, 16'h0);
    half(); finish_cycle();
    set_in(0, 0, 0, 0, 0, 0, 3'd0, 16'h0, 16'h0);
    half();
    chk("misalign mem_en", mem_en, 1'b0);
    chk("misalign valid_out", valid_out, 1'b1);
    chk("misalign err_out", err_out, 1'b1);
    chk("misalign RegWrite_out", RegWrite_out, 1'b0);
    finish_cycle();
`endif

    halted_cycles = 0;
    for (int i = 0; i < 3000; i++) begin
      applyStimulus();
      halted_cycles = mhalted ? halted_cycles + 1 : 0;
      if ($urandom_range(0, 59) == 0 || halted_cycles > 4) begin
        do_reset();
        halted_cycles = 0;
      end
      half();
      finish_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
